// File: rtl/ram_cmd_pkg.sv
// Shared opcodes, FSM state encoding and response payload for the RAM command sequencer.
package ram_cmd_pkg;

  // Default geometry; the response payload struct below is sized from these.
  localparam int unsigned CFG_ADDR_W = 4;
  localparam int unsigned CFG_DATA_W = 4;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_CHECK = 2'b11;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWr      = 3'd1,
    StRdWait  = 3'd2,
    StRsp     = 3'd3,
    StFill    = 3'd4,
    StChkWait = 3'd5,
    StChkCmp  = 3'd6
  } state_e;

  typedef struct packed {
    logic                  err;
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } rsp_t;

endpackage

// File: rtl/ram_cmd_sequencer_if.sv
// Command and response channels between a command master and the RAM sequencer.
interface ram_cmd_sequencer_if #(
  parameter int unsigned ADDR_W = ram_cmd_pkg::CFG_ADDR_W,
  parameter int unsigned DATA_W = ram_cmd_pkg::CFG_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_addr;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

endinterface

// File: rtl/ram_addr_walker.sv
// Loadable address counter that walks from a start address up to the top address and
// stops there; last flags the top address so callers never step past it.
module ram_addr_walker #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] start,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] TopAddr = '1;

  logic [ADDR_W-1:0] addr_q;

  // Address register: load wins over step; stepping at top is suppressed to avoid wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (load) begin
      addr_q <= start;
    end else if (step && (addr_q != TopAddr)) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  assign addr = addr_q;
  assign last = (addr_q == TopAddr);

endmodule

// File: rtl/ram_cmd_sequencer.sv
// Command front-end for a single-port RAM: single write/read, fill-to-top and
// check-to-top, with read and check results returned on a valid/ready response channel.
module ram_cmd_sequencer
  import ram_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W = CFG_ADDR_W,
  parameter int unsigned DATA_W = CFG_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_cmd_sequencer_if.slave bus,
  output logic               busy,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  // Wait counter value on which read data is valid for the current address.
  localparam logic [1:0] LatLast  = 2'(RD_LAT);
  // Last count spent in StChkWait before moving to the compare cycle.
  localparam logic [1:0] WaitLast = (RD_LAT == 0) ? 2'd0 : 2'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;
  logic [DATA_W-1:0] bad_data_q, bad_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  rsp_t              rsp_q, rsp_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              cur_bad;
  logic              walk_load;
  logic              walk_step;
  logic              walk_last;
  logic [ADDR_W-1:0] walk_addr;

  ram_addr_walker #(
    .ADDR_W (ADDR_W)
  ) u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (walk_load),
    .start (bus.cmd_addr),
    .step  (walk_step),
    .addr  (walk_addr),
    .last  (walk_last)
  );

  assign bus.cmd_ready = (state_q == StIdle) & rst_n;
  assign accept        = bus.cmd_valid & bus.cmd_ready;
  assign cur_bad       = (mem_rdata != data_q);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    data_d      = data_q;
    mis_d       = mis_q;
    bad_addr_d  = bad_addr_q;
    bad_data_d  = bad_data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    mem_we_d    = 1'b0;
    walk_load   = 1'b0;
    walk_step   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          data_d    = bus.cmd_data;
          walk_load = 1'b1;
          wait_d    = 2'd0;
          case (bus.cmd_op)
            OP_WRITE: begin
              state_d  = StWr;
              mem_we_d = 1'b1;
            end
            OP_READ: begin
              state_d = StRdWait;
            end
            OP_FILL: begin
              state_d  = StFill;
              mem_we_d = 1'b1;
            end
            OP_CHECK: begin
              mis_d   = 1'b0;
              state_d = (RD_LAT == 0) ? StChkCmp : StChkWait;
            end
            default: state_d = StIdle;
          endcase
        end
      end

      StWr: begin
        state_d = StIdle;
      end

      StRdWait: begin
        if (wait_q == LatLast) begin
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_d.err   = 1'b0;
          rsp_d.addr  = walk_addr;
          rsp_d.data  = mem_rdata;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      StRsp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      StFill: begin
        if (walk_last) begin
          state_d = StIdle;
        end else begin
          walk_step = 1'b1;
          mem_we_d  = 1'b1;
        end
      end

      StChkWait: begin
        if (wait_q == WaitLast) begin
          wait_d  = 2'd0;
          state_d = StChkCmp;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end

      StChkCmp: begin
        // Only the first mismatch is kept; later ones are ignored.
        if (!mis_q && cur_bad) begin
          mis_d      = 1'b1;
          bad_addr_d = walk_addr;
          bad_data_d = mem_rdata;
        end
        if (walk_last) begin
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          if (mis_q) begin
            rsp_d.err  = 1'b1;
            rsp_d.addr = bad_addr_q;
            rsp_d.data = bad_data_q;
          end else if (cur_bad) begin
            rsp_d.err  = 1'b1;
            rsp_d.addr = walk_addr;
            rsp_d.data = mem_rdata;
          end else begin
            rsp_d.err  = 1'b0;
            rsp_d.addr = walk_addr;
            rsp_d.data = data_q;
          end
        end else begin
          walk_step = 1'b1;
          wait_d    = 2'd0;
          state_d   = (RD_LAT == 0) ? StChkCmp : StChkWait;
        end
      end

      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset aborts any walk and drops mem_we immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_q      <= 2'd0;
      data_q      <= '0;
      mis_q       <= 1'b0;
      bad_addr_q  <= '0;
      bad_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      data_q      <= data_d;
      mis_q       <= mis_d;
      bad_addr_q  <= bad_addr_d;
      bad_data_q  <= bad_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
    end
  end

  assign busy          = busy_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = walk_addr;
  assign mem_wdata     = data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.rsp_addr  = rsp_q.addr;
  assign bus.rsp_data  = rsp_q.data;

endmodule

// File: tb/tb_ram_cmd_sequencer.sv
// Self-checking bench for ram_cmd_sequencer: directed scenarios then random commands,
// checked against an array-based model of RAM contents and command results.
module tb_ram_cmd_sequencer;
  import ram_cmd_pkg::*;

  localparam int RdLat = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [3:0] mem_wdata;
  logic [3:0] mem_rdata;

  ram_cmd_sequencer_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  ram_cmd_sequencer #(
    .ADDR_W (4),
    .DATA_W (4),
    .RD_LAT (RdLat)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM with 1-cycle read; also logs every write it takes.
  logic [3:0] ram [16];
  int         wq_a [$];
  int         wq_d [$];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wq_a.push_back(int'(mem_addr));
      wq_d.push_back(int'(mem_wdata));
    end
    mem_rdata <= ram[mem_addr];
  end

  logic [3:0] model_mem [16];
  int         ea [$];
  int         ed [$];
  int         total = 0;
  int         bad = 0;
  int         acc_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_accept", bus.cmd_ready, 1'b1);
    acc_cyc = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, input logic e_err, input logic [3:0] e_addr,
                         input logic [3:0] e_data, input int e_lat);
    int n = 0;
    while (!bus.rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("rsp_seen", bus.rsp_valid, 1'b1);
    if (!bus.rsp_valid) return;
    check_eq("rsp_lat", cyc - acc_cyc, e_lat);
    for (int k = 0; k <= hold; k++) begin
      check_eq("rsp_err", bus.rsp_err, e_err);
      check_eq("rsp_addr", bus.rsp_addr, e_addr);
      check_eq("rsp_data", bus.rsp_data, e_data);
      check_eq("rsp_cmd_ready", bus.cmd_ready, 1'b0);
      if (k < hold) @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("rsp_drop", bus.rsp_valid, 1'b0);
  endtask

  task automatic wait_idle();
    int n = 0;
    bit stray = 1'b0;
    while (busy && n < 300) begin
      if (bus.rsp_valid) stray = 1'b1;
      @(negedge clk);
      n++;
    end
    check_eq("idle", busy, 1'b0);
    check_eq("idle_ready", bus.cmd_ready, 1'b1);
    check_eq("no_stray_rsp", stray, 1'b0);
  endtask

  task automatic check_writes();
    check_eq("wr_count", wq_a.size(), ea.size());
    for (int i = 0; i < ea.size() && i < wq_a.size(); i++) begin
      check_eq("wr_addr", wq_a[i], ea[i]);
      check_eq("wr_data", wq_d[i], ed[i]);
    end
    wq_a.delete();
    wq_d.delete();
    ea.delete();
    ed.delete();
  endtask

  // Model the command from the rules, issue it, then compare everything it produced.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d,
                         input int hold, input bit early);
    logic       e_err = 1'b0;
    logic [3:0] e_addr = a;
    logic [3:0] e_data = 4'h0;
    int         n_addr = 16 - int'(a);
    wq_a.delete();
    wq_d.delete();
    ea.delete();
    ed.delete();
    case (op)
      OP_WRITE: begin
        ea.push_back(int'(a));
        ed.push_back(int'(d));
        model_mem[a] = d;
      end
      OP_READ: e_data = model_mem[a];
      OP_FILL: begin
        for (int i = int'(a); i < 16; i++) begin
          ea.push_back(i);
          ed.push_back(int'(d));
          model_mem[i] = d;
        end
      end
      default: begin
        e_addr = 4'hF;
        e_data = d;
        for (int i = int'(a); i < 16; i++) begin
          if (model_mem[i] != d) begin
            e_err  = 1'b1;
            e_addr = 4'(i);
            e_data = model_mem[i];
            break;
          end
        end
      end
    endcase
    send_cmd(op, a, d);
    if (early) bus.rsp_ready = 1'b1;
    if (op == OP_READ || op == OP_CHECK)
      get_rsp(early ? 0 : hold, e_err, e_addr, e_data, n_addr * 0 + ((op == OP_READ) ? 1 : n_addr) * (RdLat + 1) + 1);
    bus.rsp_ready = 1'b0;
    wait_idle();
    check_writes();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] e_data;
    int         n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = 4'h0;
    bus.cmd_data  = 4'h0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_outputs", {mem_we, mem_addr, mem_wdata, busy, bus.rsp_valid, bus.rsp_err,
                             bus.rsp_addr, bus.rsp_data}, 0);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", bus.cmd_ready, 1'b1);

    // Write then read back.
    run_cmd(OP_WRITE, 4'd3, 4'hA, 0, 1'b0);
    run_cmd(OP_READ, 4'd3, 4'h0, 0, 1'b0);
    // Fill the top four addresses only.
    run_cmd(OP_FILL, 4'd12, 4'h5, 0, 1'b0);
    // Full fill then a passing check, ready raised early.
    run_cmd(OP_FILL, 4'd0, 4'h7, 0, 1'b0);
    run_cmd(OP_CHECK, 4'd0, 4'h7, 0, 1'b1);
    // Two corruptions; only the first must be reported.
    run_cmd(OP_WRITE, 4'd9, 4'h2, 0, 1'b0);
    run_cmd(OP_WRITE, 4'd11, 4'h3, 0, 1'b0);
    run_cmd(OP_CHECK, 4'd4, 4'h7, 2, 1'b0);

    // Backpressure with a WRITE pending behind the response.
    e_data = model_mem[5];
    send_cmd(OP_READ, 4'd5, 4'h0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_rsp_seen", bus.rsp_valid, 1'b1);
    check_eq("bp_rsp_lat", cyc - acc_cyc, RdLat + 2);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_addr  = 4'd8;
    bus.cmd_data  = 4'hE;
    for (int k = 0; k < 6; k++) begin
      check_eq("bp_valid", bus.rsp_valid, 1'b1);
      check_eq("bp_data", bus.rsp_data, e_data);
      check_eq("bp_addr", bus.rsp_addr, 4'd5);
      check_eq("bp_err", bus.rsp_err, 1'b0);
      check_eq("bp_cmd_ready", bus.cmd_ready, 1'b0);
      check_eq("bp_no_we", mem_we, 1'b0);
      if (k < 5) @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("bp_rsp_drop", bus.rsp_valid, 1'b0);
    check_eq("bp_wr_ready", bus.cmd_ready, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check_eq("bp_wr_busy", busy, 1'b1);
    wait_idle();
    model_mem[8] = 4'hE;
    ea.push_back(8);
    ed.push_back(14);
    check_writes();

    // Reset in the middle of a fill, while address 6 is being written.
    send_cmd(OP_FILL, 4'd0, 4'hC);
    n = 0;
    while (!(mem_we && mem_addr == 4'd6) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_at6", mem_addr, 4'd6);
    rst_n = 1'b0;
    #1;
    check_eq("abort_outputs", {mem_we, mem_addr, mem_wdata, busy, bus.rsp_valid, bus.rsp_err,
                               bus.rsp_addr, bus.rsp_data}, 0);
    check_eq("abort_cmd_ready", bus.cmd_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", bus.cmd_ready, 1'b1);
    check_eq("abort_busy", busy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      model_mem[i] = 4'hC;
      ea.push_back(i);
      ed.push_back(12);
    end
    check_writes();
    for (int i = 0; i < 16; i++) check_eq("abort_ram", ram[i], model_mem[i]);

    // Random commands against the model.
    for (int it = 0; it < 40; it++) begin
      logic [1:0] op;
      logic [3:0] a;
      logic [3:0] d;
      op = 2'($urandom_range(0, 3));
      a  = 4'($urandom_range(0, 15));
      d  = 4'($urandom_range(0, 15));
      if (op == OP_CHECK && $urandom_range(0, 1) == 1) d = model_mem[a];
      run_cmd(op, a, d, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 16; i++) check_eq("final_ram", ram[i], model_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
